// File: rtl/axi_udp_pkg.sv
// Shared constants and types for the Ethernet TX framing path.
package axi_udp_pkg;

   localparam int ETH_HDR_LEN   = 14;
   localparam int ETH_MIN_FRAME = 60;

   localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
   localparam logic [15:0] ETHERTYPE_IP  = 16'h0800;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PAYLOAD,
      PAD,
      DONE
   } tx_state_t;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational requester selection: round-robin from pointer+1, or fixed
// priority with index 0 highest. The pointer register lives in the caller.
module axi_rr_arbiter #(
   parameter int N    = 4,
   parameter int MODE = 0
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   pointer,
   input  logic         enable,
   output logic [N-1:0] grant,
   output logic [2:0]   idx
);

   logic found;

   // Pick a single winner; round-robin scans indices above the pointer, then wraps.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      grant = '0;
      idx   = '0;
      found = 1'b0;
      if (enable) begin
         if (MODE == 1) begin
            for (int i = 0; i < N; i++) begin
               if (!found && req[i]) begin
                  found    = 1'b1;
                  grant[i] = 1'b1;
                  idx      = 3'(i);
               end
            end
         end else begin
            for (int i = 0; i < N; i++) begin
               if (!found && req[i] && (i > int'(pointer))) begin
                  found    = 1'b1;
                  grant[i] = 1'b1;
                  idx      = 3'(i);
               end
            end
            for (int i = 0; i < N; i++) begin
               if (!found && req[i] && (i <= int'(pointer))) begin
                  found    = 1'b1;
                  grant[i] = 1'b1;
                  idx      = 3'(i);
               end
            end
         end
      end
   end

endmodule

// File: rtl/axi_eth_tx_mux.sv
// Ethernet TX mux: arbitrates among frame sources, emits the latched 14-byte
// header, passes the payload through and zero-pads up to the minimum length.
module axi_eth_tx_mux
   import axi_udp_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int ARB_MODE  = 0,
   parameter int MIN_FRAME = ETH_MIN_FRAME,
   parameter int CNT_W     = 16
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic [NUM_PORTS-1:0]    port_req,
   output logic [NUM_PORTS-1:0]    port_ack,
   input  logic [NUM_PORTS*48-1:0] port_dst_mac,
   input  logic [NUM_PORTS*48-1:0] port_src_mac,
   input  logic [NUM_PORTS*16-1:0] port_ethertype,
   input  logic [NUM_PORTS*8-1:0]  port_axis_tdata,
   input  logic [NUM_PORTS-1:0]    port_axis_tlast,
   input  logic [NUM_PORTS-1:0]    port_axis_tvalid,
   output logic [NUM_PORTS-1:0]    port_axis_tready,
   output logic [7:0]              mac_axis_tdata,
   output logic                    mac_axis_tlast,
   output logic                    mac_axis_tvalid,
   input  logic                    mac_axis_tready,
   output logic                    busy,
   output logic [2:0]              grant_idx
);

   localparam logic [CNT_W:0] MIN_CNT = (CNT_W+1)'(MIN_FRAME);

   tx_state_t              state;
   logic [3:0]             hdr_idx;
   logic [CNT_W-1:0]       byte_cnt;
   logic [2:0]             rr_ptr;
   logic [2:0]             grant_r;
   logic [NUM_PORTS-1:0]   grant_oh;
   logic [47:0]            dst_r;
   logic [47:0]            src_r;
   logic [15:0]            type_r;
   logic                   busy_r;
   logic [NUM_PORTS-1:0]   ack_r;

   logic [NUM_PORTS-1:0]   arb_grant;
   logic [2:0]             arb_idx;
   logic [47:0]            sel_dst;
   logic [47:0]            sel_src;
   logic [15:0]            sel_type;
   logic [7:0]             pay_data;
   logic                   pay_valid;
   logic                   pay_last;
   logic [111:0]           hdr_shift;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   at_min;
   logic                   beat;

   axi_rr_arbiter #(
      .N    (NUM_PORTS),
      .MODE (ARB_MODE)
   ) u_arb (
      .req     (port_req),
      .pointer (rr_ptr),
      .enable  (state == IDLE),
      .grant   (arb_grant),
      .idx     (arb_idx)
   );

   // Header fields of the arbitration winner, latched on the grant cycle.
   always_comb begin
      sel_dst  = '0;
      sel_src  = '0;
      sel_type = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (arb_grant[i]) begin
            sel_dst  = port_dst_mac[48*i +: 48];
            sel_src  = port_src_mac[48*i +: 48];
            sel_type = port_ethertype[16*i +: 16];
         end
      end
   end

   // Payload stream of the granted port.
   always_comb begin
      pay_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_oh[i]) pay_data = port_axis_tdata[8*i +: 8];
      end
      pay_valid = |(port_axis_tvalid & grant_oh);
      pay_last  = |(port_axis_tlast & grant_oh);
   end

   // Byte bookkeeping: saturating increment and minimum-length test for the current beat.
   always_comb begin
      hdr_shift = {dst_r, src_r, type_r} << {hdr_idx, 3'b000};
      cnt_inc   = (byte_cnt == '1) ? byte_cnt : byte_cnt + CNT_W'(1);
      at_min    = ({1'b0, byte_cnt} + (CNT_W+1)'(1)) >= MIN_CNT;
      beat      = mac_axis_tvalid & mac_axis_tready;
   end

   // MAC-side byte stream and per-port ready, selected by the current state.
   always_comb begin
      mac_axis_tdata   = '0;
      mac_axis_tvalid  = 1'b0;
      mac_axis_tlast   = 1'b0;
      port_axis_tready = '0;
      case (state)
         HDR: begin
            mac_axis_tdata  = hdr_shift[111:104];
            mac_axis_tvalid = 1'b1;
         end
         PAYLOAD: begin
            mac_axis_tdata   = pay_data;
            mac_axis_tvalid  = pay_valid;
            mac_axis_tlast   = pay_last & at_min;
            port_axis_tready = grant_oh & {NUM_PORTS{mac_axis_tready}};
         end
         PAD: begin
            mac_axis_tvalid = 1'b1;
            mac_axis_tlast  = at_min;
         end
         default: ;
      endcase
   end

   // Frame sequencer: grant, header, payload, pad, acknowledge.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         // NOTE: the small header registers are reset too, so every output is 0 out of reset.
         state    <= IDLE;
         hdr_idx  <= '0;
         byte_cnt <= '0;
         rr_ptr   <= '0;
         grant_r  <= '0;
         grant_oh <= '0;
         dst_r    <= '0;
         src_r    <= '0;
         type_r   <= '0;
         busy_r   <= 1'b0;
         ack_r    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         ack_r <= '0;
         case (state)
            IDLE: begin
               if (|arb_grant) begin
                  grant_oh <= arb_grant;
                  grant_r  <= arb_idx;
                  dst_r    <= sel_dst;
                  src_r    <= sel_src;
                  type_r   <= sel_type;
                  busy_r   <= 1'b1;
                  hdr_idx  <= '0;
                  state    <= HDR;
               end
            end
            HDR: begin
               if (beat) begin
                  if (hdr_idx == 4'(ETH_HDR_LEN - 1)) begin
                     hdr_idx  <= '0;
                     byte_cnt <= CNT_W'(ETH_HDR_LEN);
                     state    <= PAYLOAD;
                  end else begin
                     hdr_idx <= hdr_idx + 4'd1;
                  end
               end
            end
            PAYLOAD: begin
               if (beat) begin
                  byte_cnt <= cnt_inc;
                  if (pay_last) begin
                     if (at_min) begin
                        ack_r <= grant_oh;
                        state <= DONE;
                     end else begin
                        state <= PAD;
                     end
                  end
               end
            end
            PAD: begin
               if (beat) begin
                  byte_cnt <= cnt_inc;
                  if (at_min) begin
                     ack_r <= grant_oh;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               rr_ptr <= grant_r;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign port_ack  = ack_r;
   assign busy      = busy_r;
   assign grant_idx = grant_r;

endmodule

// File: tb/tb_axi_eth_tx_mux.sv
// Randomized bench for axi_eth_tx_mux: two instances (round-robin with 60-byte
// padding, fixed priority without padding) checked against a frame-level model.
module tb_axi_eth_tx_mux;

   localparam int NP = 4;

   typedef struct packed {
      int port;
      int nbytes;
   } frame_t;

   logic        clk = 1'b0;
   logic        rstn       [2];
   logic [3:0]  req        [2];
   logic [3:0]  ack        [2];
   logic [191:0] dst_in    [2];
   logic [191:0] src_in    [2];
   logic [63:0] et_in      [2];
   logic [31:0] td_in      [2];
   logic [3:0]  tl_in      [2];
   logic [3:0]  tv_in      [2];
   logic [3:0]  tr_out     [2];
   logic [7:0]  m_td       [2];
   logic        m_tl       [2];
   logic        m_tv       [2];
   logic        m_tr       [2];
   logic        busy       [2];
   logic [2:0]  gidx       [2];

   // Bench model state
   int          minf  [2] = '{60, 0};
   int          amode [2] = '{0, 1};
   logic [7:0]  src_q [8][$];
   logic [7:0]  exp_b [2][$];
   frame_t      exp_f [2][$];
   int          ack_log [2][$];
   logic [47:0] m_dst [2][4];
   logic [47:0] m_src [2][4];
   logic [15:0] m_et  [2][4];
   logic [3:0]  req_st [2];
   logic        rst_st [2];
   int          rr_model [2];
   int          cur_n [2];
   int          bad [2];
   int          tr_bad [2];
   bit          ack_due [2];
   bit          post_ack [2];
   bit          stall_en;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   axi_eth_tx_mux #(.NUM_PORTS(4), .ARB_MODE(0), .MIN_FRAME(60), .CNT_W(16)) dut_a (
      .clk(clk), .aresetn(rstn[0]), .port_req(req[0]), .port_ack(ack[0]),
      .port_dst_mac(dst_in[0]), .port_src_mac(src_in[0]), .port_ethertype(et_in[0]),
      .port_axis_tdata(td_in[0]), .port_axis_tlast(tl_in[0]), .port_axis_tvalid(tv_in[0]),
      .port_axis_tready(tr_out[0]), .mac_axis_tdata(m_td[0]), .mac_axis_tlast(m_tl[0]),
      .mac_axis_tvalid(m_tv[0]), .mac_axis_tready(m_tr[0]), .busy(busy[0]), .grant_idx(gidx[0])
   );

   axi_eth_tx_mux #(.NUM_PORTS(4), .ARB_MODE(1), .MIN_FRAME(0), .CNT_W(16)) dut_b (
      .clk(clk), .aresetn(rstn[1]), .port_req(req[1]), .port_ack(ack[1]),
      .port_dst_mac(dst_in[1]), .port_src_mac(src_in[1]), .port_ethertype(et_in[1]),
      .port_axis_tdata(td_in[1]), .port_axis_tlast(tl_in[1]), .port_axis_tvalid(tv_in[1]),
      .port_axis_tready(tr_out[1]), .mac_axis_tdata(m_td[1]), .mac_axis_tlast(m_tl[1]),
      .mac_axis_tvalid(m_tv[1]), .mac_axis_tready(m_tr[1]), .busy(busy[1]), .grant_idx(gidx[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic string tg(input string s, input int d);
      return $sformatf("%s[dut%0d]", s, d);
   endfunction

   // Expected frame = header, payload, zero pad up to the minimum length.
   task automatic add_frame(input int d, input int p);
      int n;
      int q;
      q = d*NP + p;
      for (int i = 0; i < 6; i++) exp_b[d].push_back(m_dst[d][p][47-8*i -: 8]);
      for (int i = 0; i < 6; i++) exp_b[d].push_back(m_src[d][p][47-8*i -: 8]);
      exp_b[d].push_back(m_et[d][p][15:8]);
      exp_b[d].push_back(m_et[d][p][7:0]);
      n = 14;
      foreach (src_q[q][i]) begin
         exp_b[d].push_back(src_q[q][i]);
         n++;
      end
      while (n < minf[d]) begin
         exp_b[d].push_back(8'h00);
         n++;
      end
      exp_f[d].push_back(frame_t'{port: p, nbytes: n});
   endtask

   task automatic launch_port(input int d, input int p, input int len,
                              input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
      m_dst[d][p] = dst;
      m_src[d][p] = src;
      m_et[d][p]  = et;
      src_q[d*NP+p].delete();
      for (int i = 0; i < len; i++) src_q[d*NP+p].push_back(8'($urandom));
      req_st[d][p] = 1'b1;
   endtask

   task automatic rand_port(input int d, input int p, input int len);
      launch_port(d, p, len, 48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 16'($urandom));
   endtask

   // Service order of a simultaneous batch, then expected frames in that order.
   task automatic predict(input int d, input logic [3:0] mask);
      int ord[$];
      int p;
      if (amode[d] == 1) begin
         for (int i = 0; i < NP; i++) if (mask[i]) ord.push_back(i);
      end else begin
         for (int k = 1; k <= NP; k++) begin
            p = (rr_model[d] + k) % NP;
            if (mask[p]) ord.push_back(p);
         end
      end
      foreach (ord[i]) add_frame(d, ord[i]);
      if (ord.size() > 0) rr_model[d] = ord[ord.size()-1];
   endtask

   // One clock: drive on the falling edge, sample 1 ns later, score both DUTs.
   task automatic cycle();
      int q;
      bit started;
      logic [3:0] oh;
      frame_t fr;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         rstn[d] = rst_st[d];
         m_tr[d] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int p = 0; p < NP; p++) begin
            q = d*NP + p;
            started = (exp_f[d].size() > 0) && (cur_n[d] > 0) && (exp_f[d][0].port == p);
            if (started) req_st[d][p] = 1'b0;
            req[d][p]   = req_st[d][p];
            tv_in[d][p] = (src_q[q].size() > 0) && (!stall_en || ($urandom_range(0, 1) == 1));
            td_in[d][p*8 +: 8] = tv_in[d][p] ? src_q[q][0] : 8'($urandom);
            tl_in[d][p] = (src_q[q].size() == 1);
            dst_in[d][p*48 +: 48] = started ? 48'({$urandom, $urandom}) : m_dst[d][p];
            src_in[d][p*48 +: 48] = started ? 48'({$urandom, $urandom}) : m_src[d][p];
            et_in[d][p*16 +: 16]  = started ? 16'($urandom) : m_et[d][p];
         end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         if (ack_due[d]) begin
            oh = 4'(1) << exp_f[d][0].port;
            check(tg("ack_pulse", d), ack[d], oh);
            check(tg("busy_in_done", d), busy[d], 1);
            for (int p = 0; p < NP; p++) if (ack[d][p]) ack_log[d].push_back(p);
            req_st[d][exp_f[d][0].port] = 1'b0;
            fr = exp_f[d].pop_front();
            ack_due[d]  = 1'b0;
            post_ack[d] = 1'b1;
         end else begin
            if (post_ack[d]) begin
               check(tg("busy_after_ack", d), busy[d], 0);
               post_ack[d] = 1'b0;
            end
            check(tg("ack_idle", d), ack[d], 0);
         end
         oh = (exp_f[d].size() > 0) ? 4'(1) << exp_f[d][0].port : 4'd0;
         if ((tr_out[d] & ~oh) != 4'd0) tr_bad[d]++;
         if (m_tv[d] && m_tr[d]) begin
            cur_n[d]++;
            if (exp_b[d].size() == 0 || m_td[d] !== exp_b[d][0]) bad[d]++;
            if (exp_b[d].size() > 0) void'(exp_b[d].pop_front());
            if (m_tl[d]) begin
               check(tg("frame_expected", d), exp_f[d].size() > 0, 1);
               if (exp_f[d].size() > 0) begin
                  check(tg("frame_len", d), cur_n[d], exp_f[d][0].nbytes);
                  check(tg("grant_idx", d), gidx[d], exp_f[d][0].port);
                  ack_due[d] = 1'b1;
               end
               check(tg("frame_bad_bytes", d), bad[d], 0);
               check(tg("tready_ungranted", d), tr_bad[d], 0);
               cur_n[d] = 0; bad[d] = 0; tr_bad[d] = 0;
            end
         end
         for (int p = 0; p < NP; p++) begin
            q = d*NP + p;
            if (tv_in[d][p] && tr_out[d][p] && src_q[q].size() > 0) void'(src_q[q].pop_front());
         end
      end
   endtask

   function automatic bit all_idle();
      return exp_f[0].size() == 0 && exp_f[1].size() == 0 &&
             !ack_due[0] && !ack_due[1] && !post_ack[0] && !post_ack[1];
   endfunction

   task automatic run_until_idle(input int budget);
      int k;
      k = 0;
      while (k < budget && !all_idle()) begin
         cycle();
         k++;
      end
      check("drain_within_budget", k < budget, 1);
   endtask

   int obs;
   int k;
   logic [3:0] mask;

   initial begin
      stall_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
         rst_st[d] = 1'b0; rstn[d] = 1'b0; req_st[d] = '0; req[d] = '0;
         dst_in[d] = '0; src_in[d] = '0; et_in[d] = '0; td_in[d] = '0;
         tl_in[d] = '0; tv_in[d] = '0; m_tr[d] = 1'b0;
         rr_model[d] = 0; cur_n[d] = 0; bad[d] = 0; tr_bad[d] = 0;
         ack_due[d] = 1'b0; post_ack[d] = 1'b0;
         for (int p = 0; p < NP; p++) begin
            m_dst[d][p] = '0; m_src[d][p] = '0; m_et[d][p] = '0;
         end
      end

      // Reset state
      cycle();
      cycle();
      for (int d = 0; d < 2; d++) begin
         check(tg("rst_tvalid", d), m_tv[d], 0);
         check(tg("rst_tlast", d), m_tl[d], 0);
         check(tg("rst_tdata", d), m_td[d], 0);
         check(tg("rst_busy", d), busy[d], 0);
         check(tg("rst_grant_idx", d), gidx[d], 0);
         check(tg("rst_tready", d), tr_out[d], 0);
         rst_st[d] = 1'b1;
      end
      cycle();

      // Simultaneous requests from ports 0, 2, 3 with the pointer at 0
      for (int d = 0; d < 2; d++) begin
         ack_log[d].delete();
         rand_port(d, 0, 5);
         rand_port(d, 2, 30);
         rand_port(d, 3, 50);
         predict(d, 4'b1101);
      end
      run_until_idle(3000);
      for (int d = 0; d < 2; d++) begin
         obs = (ack_log[d].size() == 3) ? ack_log[d][0]*256 + ack_log[d][1]*16 + ack_log[d][2] : -1;
         check(tg("arb_order", d), obs, (d == 0) ? 'h230 : 'h023);
      end

      // ARP-style frame on port 1, 28-byte payload; first header byte one cycle after grant
      for (int d = 0; d < 2; d++) begin
         launch_port(d, 1, 28, 48'hffff_ffff_ffff, 48'h0102_0304_0506, 16'h0806);
         predict(d, 4'b0010);
      end
      cycle();
      check("hdr_latency_grant_cycle", m_tv[0], 0);
      cycle();
      check("hdr_latency_first_byte", m_tv[0], 1);
      check("hdr_first_byte", m_td[0], 8'hff);
      run_until_idle(3000);

      // Port 2, 100-byte payload: no padding
      for (int d = 0; d < 2; d++) begin
         rand_port(d, 2, 100);
         predict(d, 4'b0100);
      end
      run_until_idle(3000);

      // 1-byte payload: 45 pad bytes on the padded instance, 15-byte frame on the other
      for (int d = 0; d < 2; d++) begin
         rand_port(d, 0, 1);
         predict(d, 4'b0001);
      end
      run_until_idle(3000);

      // Random batches with random backpressure and source gaps
      stall_en = 1'b1;
      for (int b = 0; b < 10; b++) begin
         for (int d = 0; d < 2; d++) begin
            mask = 4'($urandom_range(1, 15));
            for (int p = 0; p < NP; p++) if (mask[p]) rand_port(d, p, $urandom_range(1, 80));
            predict(d, mask);
         end
         run_until_idle(20000);
      end
      stall_en = 1'b0;

      // Reset pulsed while byte 20 of a frame is on the bus
      rand_port(0, 3, 40);
      predict(0, 4'b1000);
      k = 0;
      while (cur_n[0] < 19 && k < 200) begin
         cycle();
         k++;
      end
      check("reach_byte20", cur_n[0], 19);
      @(negedge clk);
      rst_st[0] = 1'b0;
      rstn[0]   = 1'b0;
      #1;
      check("midrst_tvalid", m_tv[0], 0);
      check("midrst_busy", busy[0], 0);
      check("midrst_ack", ack[0], 0);
      check("midrst_tready", tr_out[0], 0);
      for (int p = 0; p < NP; p++) src_q[p].delete();
      exp_b[0].delete(); exp_f[0].delete();
      cur_n[0] = 0; bad[0] = 0; tr_bad[0] = 0;
      ack_due[0] = 1'b0; post_ack[0] = 1'b0;
      req_st[0] = '0; rr_model[0] = 0;
      cycle();
      cycle();
      rst_st[0] = 1'b1;
      cycle();
      rand_port(0, 3, 10);
      predict(0, 4'b1000);
      run_until_idle(3000);

      for (int d = 0; d < 2; d++) check(tg("tready_ungranted_final", d), tr_bad[d], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
